// File: rtl/gate_sweep_pkg.sv
// ---------------------------------------------------------------------------
// gate_sweep_pkg : shared state encoding and sizing for the gate sweep checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gate_sweep_pkg;

  localparam int NUM_VECTORS       = 4;
  localparam int MAX_SETTLE_CYCLES = 15;
  localparam int SETTLE_CNT_W      = $clog2(MAX_SETTLE_CYCLES + 1);

  typedef logic [SETTLE_CNT_W-1:0] settle_cnt_t;
  typedef logic [1:0]              vec_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ---------------------------------------------------------------------------
// gate_ref_model : expected responses of the two-input gate block
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_ref_model (
  input  logic x,
  input  logic y,
  output logic exp_and,
  output logic exp_or,
  output logic exp_not,
  output logic exp_nand,
  output logic exp_nor
);

  assign exp_and  = x & y;
  assign exp_or   = x | y;
  assign exp_not  = ~x;
  assign exp_nand = ~(x & y);
  assign exp_nor  = ~(x | y);

endmodule

`default_nettype wire

// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker : drives all four {x,y} vectors into a gate block and
// checks the AND/OR/NOT/NAND/NOR responses, reporting per-vector failures.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       not_in,
  input  logic       nand_in,
  input  logic       nor_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  import gate_sweep_pkg::*;

  localparam settle_cnt_t SETTLE_LOAD = settle_cnt_t'(SETTLE_CYCLES - 1);
  localparam vec_idx_t    LAST_IDX    = vec_idx_t'(NUM_VECTORS - 1);

  state_t      state;
  state_t      state_next;
  settle_cnt_t settle_cnt;
  vec_idx_t    vec_idx;

  logic       exp_and;
  logic       exp_or;
  logic       exp_not;
  logic       exp_nand;
  logic       exp_nor;
  logic       mismatch;
  logic [2:0] err_next;

  gate_ref_model u_ref (
    .x        (x),
    .y        (y),
    .exp_and  (exp_and),
    .exp_or   (exp_or),
    .exp_not  (exp_not),
    .exp_nand (exp_nand),
    .exp_nor  (exp_nor)
  );

  assign mismatch = (and_in  != exp_and)  | (or_in  != exp_or) |
                    (not_in  != exp_not)  | (nand_in != exp_nand) |
                    (nor_in  != exp_nor);
  assign err_next = err_count + {2'b00, mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == '0) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy       = 1'b1;
        state_next = (vec_idx == LAST_IDX) ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // pass is resolved on entry to DONE from err_next so the last vector counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      vec_idx    <= '0;
      x          <= 1'b0;
      y          <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            settle_cnt <= SETTLE_LOAD;
            vec_idx    <= '0;
            {x, y}     <= 2'b00;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          err_count         <= err_next;
          fail_vec[vec_idx] <= mismatch;
          if (vec_idx == LAST_IDX) begin
            {x, y} <= 2'b00;
            pass   <= (err_next == 3'd0);
          end else begin
            vec_idx    <= vec_idx + 2'd1;
            {x, y}     <= vec_idx + 2'd1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker : randomized self-checking bench for gate_sweep_checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_sweep_checker;

  localparam int S     = 4;
  localparam int PER   = S + 1;
  localparam int SWEEP = 4 * PER;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       x, y;
  logic       and_in, or_in, not_in, nand_in, nor_in;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  // Per-vector XOR mask applied to the ideal gate block {and,or,not,nand,nor}.
  logic [4:0] fault [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb begin
    {and_in, or_in, not_in, nand_in, nor_in} =
      {x & y, x | y, ~x, ~(x & y), ~(x | y)} ^ fault[{x, y}];
  end

  gate_sweep_checker #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x         (x),
    .y         (y),
    .and_in    (and_in),
    .or_in     (or_in),
    .not_in    (not_in),
    .nand_in   (nand_in),
    .nor_in    (nor_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  function automatic logic [3:0] model_fail_vec();
    logic [3:0] fv;
    for (int i = 0; i < 4; i++) fv[i] = (fault[i] != 5'd0);
    return fv;
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < 4; i++) fault[i] = 5'd0;
  endtask

  // One full sweep from a start pulse; every cycle up to two past done is checked.
  task automatic run_sweep(input logic [3:0] exp_fv, input bit rand_start);
    logic [3:0] fv_now;
    logic [2:0] err_now;
    logic [1:0] xy_now;
    logic       busy_e, done_e, pass_e;
    int         seen;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= SWEEP + 2; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      start  = (rand_start && k < SWEEP) ? 1'($urandom % 2) : 1'b0;
      seen   = (k / PER > 4) ? 4 : k / PER;
      fv_now = exp_fv & 4'((1 << seen) - 1);
      err_now = 3'($countones(fv_now));
      busy_e = (k < SWEEP);
      done_e = (k == SWEEP);
      xy_now = (k < SWEEP) ? 2'(k / PER) : 2'b00;
      pass_e = (k >= SWEEP) && (exp_fv == 4'b0000);
      tests++;
      if ({busy, done, x, y, pass, err_count, fail_vec} !==
          {busy_e, done_e, xy_now, pass_e, err_now, fv_now}) begin
        fails++;
        $display("FAIL sweep k=%0d: got busy=%b done=%b xy=%b%b pass=%b err=%0d fv=%b, want busy=%b done=%b xy=%b pass=%b err=%0d fv=%b",
                 k, busy, done, x, y, pass, err_count, fail_vec,
                 busy_e, done_e, xy_now, pass_e, err_now, fv_now);
      end
    end
  endtask

  task automatic test_reset();
    clear_faults();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({x, y, busy, done, pass, err_count, fail_vec} !== 11'b0) begin
      fails++;
      $display("FAIL reset: got xy=%b%b busy=%b done=%b pass=%b err=%0d fv=%b, want all zero",
               x, y, busy, done, pass, err_count, fail_vec);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean();
    clear_faults();
    run_sweep(4'b0000, 1'b0);
  endtask

  task automatic test_nor_stuck0();
    clear_faults();
    fault[0] = 5'b00001;
    run_sweep(4'b0001, 1'b0);
  endtask

  task automatic test_not_is_not_y();
    clear_faults();
    fault[1] = 5'b00100;
    fault[2] = 5'b00100;
    run_sweep(4'b0110, 1'b0);
  endtask

  task automatic test_random_faults();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++)
        fault[i] = ($urandom % 2 == 1) ? 5'($urandom) : 5'd0;
      run_sweep(model_fail_vec(), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    clear_faults();
    fault[0] = 5'b00001;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2 * PER + 1) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({x, y, busy, done, pass, err_count, fail_vec} !== 11'b0) begin
      fails++;
      $display("FAIL reset_mid: got xy=%b%b busy=%b done=%b pass=%b err=%0d fv=%b, want all zero",
               x, y, busy, done, pass, err_count, fail_vec);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({busy, done} !== 2'b00) begin
        fails++;
        $display("FAIL reset_hold c=%0d: got busy=%b done=%b, want 0 0", c, busy, done);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    clear_faults();
    run_sweep(4'b0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    logic [3:0] exp_fv;
    for (int i = 0; i < 4; i++)
      fault[i] = ($urandom % 2 == 1) ? 5'($urandom) : 5'd0;
    exp_fv = model_fail_vec();
    @(negedge clk) start = 1'b1;
    for (int c = 0; c < 76; c++) begin
      @(posedge clk);
      #1;
      if (c == 60) start = 1'b0;
      if (done) begin
        done_at.push_back(c);
        tests++;
        if ({pass, err_count, fail_vec} !==
            {exp_fv == 4'b0000, 3'($countones(exp_fv)), exp_fv}) begin
          fails++;
          $display("FAIL b2b_result c=%0d: got pass=%b err=%0d fv=%b, want fv=%b",
                   c, pass, err_count, fail_vec, exp_fv);
        end
      end
    end
    tests++;
    if (done_at.size() != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", done_at.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (done_at[i] != SWEEP + i * (SWEEP + 2)) begin
          fails++;
          $display("FAIL b2b_time #%0d: got cycle %0d, want %0d",
                   i, done_at[i], SWEEP + i * (SWEEP + 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_nor_stuck0();
    test_not_is_not_y();
    test_random_faults();
    test_reset_mid();
    test_back_to_back();
    test_clean();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, legal range 1..15: cycles each input vector is held before its outputs are sampled.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request one full truth-table sweep; sampled only in IDLE.
REQ-005 SHALL have port x  output  1  stimulus X to the gate block under check (MSB of the vector).
REQ-006 SHALL have port y  output  1  stimulus Y to the gate block under check (LSB of the vector).
REQ-007 SHALL have ports and_in, or_in, not_in, nand_in, nor_in  input  1 each  gate block responses.
REQ-008 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-010 SHALL have port pass  output  1  last completed sweep had zero mismatches.
REQ-011 SHALL have port err_count  output  3  number of mismatching vectors in the current or last sweep, 0..4.
REQ-012 SHALL have port fail_vec  output  4  bit i set when vector i ({x,y}=i) mismatched.

Function
REQ-013 Expected responses SHALL be AND=x&y, OR=x|y, NOT=~x, NAND=~(x&y), NOR=~(x|y); a vector mismatches if any of the five inputs differs.
REQ-014 FSM states SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE with start=1 at an edge (E0) SHALL go to SETTLE with vector index 0, clear err_count, fail_vec and pass, and load the settle counter.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle; at its closing edge, compare responses, update err_count/fail_vec, then go to SETTLE with index+1, or to DONE if index is 3.
REQ-018 Vectors SHALL be driven in order 00, 01, 10, 11; x,y SHALL be registered and stable from entry into SETTLE through the end of SAMPLE for each vector.
REQ-019 DONE SHALL last one cycle with done=1, set pass=(err_count==0) (including the final comparison), then go to IDLE.
REQ-020 done SHALL be high in the cycle that starts 4*(SETTLE_CYCLES+1) edges after E0 (20 for the default).
REQ-021 busy SHALL be high in SETTLE and SAMPLE only.
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and DONE; held-high start SHALL produce back-to-back sweeps with done period 4*(SETTLE_CYCLES+1)+2 cycles.
REQ-023 pass, err_count and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-024 In IDLE and DONE, x,y SHALL be 00.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, x=0, y=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0000, and clear the settle counter and vector index.
REQ-026 Reset asserted mid-sweep SHALL abandon the sweep without a done pulse; the first start after release SHALL run a complete fresh sweep.

Structure
REQ-027 The state encodings, NUM_VECTORS=4, and the maximum SETTLE_CYCLES value SHALL live in a shared gate_sweep_pkg definitions file.
REQ-028 The expected-response logic SHALL be a combinational sub-module gate_ref_model (inputs x,y; outputs for the five expected gate values).

Verification (SETTLE_CYCLES=4, correct gate block attached unless stated)
REQ-029 Single start pulse -> busy for 20 cycles, done at E0+20, pass=1, err_count=0, fail_vec=0000, x,y steps 00,01,10,11 every 5 cycles.
REQ-030 nor_in forced 0 -> fail_vec=0001, err_count=1, pass=0.
REQ-031 not_in wired to ~y -> fail_vec=0110, err_count=2, pass=0.
REQ-032 rst_n pulsed low during SETTLE of vector 10 -> x=y=0 and busy=0 immediately, no done; next start -> full 20-cycle sweep with pass=1.
REQ-033 start held high for 60 cycles -> done pulses 22 cycles apart; extra start pulses during busy do not change timing.
